// File: rtl/mem_load_unit.sv
// RV32I load unit: latches an issued load, reads the containing word over a
// req/ack port, then writes back the extended byte/halfword/word or reports a fault.
module mem_load_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [4:0]  rd,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;

    localparam logic [1:0] C_MISALIGN = 2'b01;
    localparam logic [1:0] C_ILLEGAL  = 2'b10;
    localparam logic [1:0] C_TIMEOUT  = 2'b11;

    localparam int unsigned     CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TO_LIM = CW'(TIMEOUT);
    localparam bit              TO_EN  = (TIMEOUT != 0);

    logic [1:0]    state_q,   state_d;
    logic [29:0]   waddr_q,   waddr_d;
    logic [1:0]    off_q,     off_d;
    logic [2:0]    funct3_q,  funct3_d;
    logic [4:0]    rd_q,      rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic [1:0]    cause_q,   cause_d;
    logic [CW-1:0] cnt_q,     cnt_d;

    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   fmt;
    logic          illegal;
    logic          misaligned;

    // Lane selection and extension of the returned word, using the latched offset/type.
    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (off_q)
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            F_LB:    fmt = {{24{byte_sel[7]}}, byte_sel};
            F_LBU:   fmt = {24'h0, byte_sel};
            F_LH:    fmt = {{16{half_sel[15]}}, half_sel};
            F_LHU:   fmt = {16'h0, half_sel};
            default: fmt = mem_rdata;
        endcase
    end

    always_comb begin
        illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        misaligned = (((funct3 == F_LH) || (funct3 == F_LHU)) && addr[0])
                   || ((funct3 == F_LW) && (addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        off_d     = off_q;
        funct3_d  = funct3_q;
        rd_d      = rd_q;
        wb_data_d = wb_data_q;
        cause_d   = cause_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    waddr_d  = addr[31:2];
                    off_d    = addr[1:0];
                    funct3_d = funct3;
                    rd_d     = rd;
                    cause_d  = 2'b00;
                    cnt_d    = '0;
                    if (illegal) begin
                        state_d = S_FAULT;
                        cause_d = C_ILLEGAL;
                    end else if (misaligned) begin
                        state_d = S_FAULT;
                        cause_d = C_MISALIGN;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // An ack on the expiring cycle still completes the load.
                if (mem_ack) begin
                    wb_data_d = fmt;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (TO_EN && (cnt_d == TO_LIM)) begin
                        state_d = S_FAULT;
                        cause_d = C_TIMEOUT;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            waddr_q   <= '0;
            off_q     <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
            cause_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            off_q     <= off_d;
            funct3_q  <= funct3_d;
            rd_q      <= rd_d;
            wb_data_q <= wb_data_d;
            cause_q   <= cause_d;
            cnt_q     <= cnt_d;
        end
    end

    // Handshake/status outputs decode straight from state so reset drops them immediately.
    always_comb begin
        mem_addr    = {waddr_q, 2'b00};
        mem_req     = (state_q == S_REQ);
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE) || (state_q == S_FAULT);
        wb_en       = (state_q == S_DONE);
        fault       = (state_q == S_FAULT);
        fault_cause = cause_q;
        wb_rd       = rd_q;
        wb_data     = wb_data_q;
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// Self-checking bench for mem_load_unit (TIMEOUT=4): directed cases plus randomized
// loads checked against a behavioural model of the load rules.
module tb_mem_load_unit;

    localparam int unsigned TO = 4;

    logic        CLK;
    logic        RST_N;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic [1:0]  fault_cause;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [31:0] exp_wb;

    mem_load_unit #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .funct3(funct3), .addr(addr), .rd(rd),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .fault(fault), .fault_cause(fault_cause)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: result of a load of the given type from a little-endian word.
    function automatic logic [31:0] ref_extend(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] sh;
        int          sv;
        sh = w >> (8 * off);
        case (f3)
            3'b000:  begin sv = int'($signed(sh[7:0]));  return 32'(sv); end
            3'b001:  begin sv = int'($signed(sh[15:0])); return 32'(sv); end
            3'b100:  return sh & 32'h0000_00FF;
            3'b101:  return sh & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    // One load issued in the current cycle; k = ack cycle (0 = never).
    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] r,
                           input int unsigned k, input logic [31:0] word);
        logic [1:0]  cause;
        int unsigned done_cyc;
        logic        ok;
        bit          ill;
        bit          mis;
        ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        mis = (((f3 == 3'd1) || (f3 == 3'd5)) && a[0]) || ((f3 == 3'd2) && (a[1:0] != 2'b00));
        ok = 1'b0;
        cause = 2'b00;
        if (ill) begin
            cause = 2'b10; done_cyc = 1;
        end else if (mis) begin
            cause = 2'b01; done_cyc = 1;
        end else if (k >= 1 && k <= TO) begin
            ok = 1'b1; done_cyc = k + 1;
        end else begin
            cause = 2'b11; done_cyc = TO + 1;
        end

        start = 1'b1; funct3 = f3; addr = a; rd = r;
        mem_ack = 1'b0;
        step();
        start = 1'b0; funct3 = 3'($urandom); addr = $urandom; rd = 5'($urandom);
        check("mem_addr", mem_addr, {a[31:2], 2'b00});
        check("wb_rd", 32'(wb_rd), 32'(r));
        for (int unsigned c = 1; c < done_cyc; c++) begin
            check("req_hi", 32'(mem_req), 32'd1);
            check("busy_req", 32'(busy), 32'd1);
            check("no_done_req", 32'(done), 32'd0);
            check("cause_clr", 32'(fault_cause), 32'd0);
            mem_ack = (c == k);
            mem_rdata = (c == k) ? word : $urandom;
            step();
        end
        if (ok) exp_wb = ref_extend(f3, a[1:0], word);
        // Random ack/data during the completion cycle must be ignored.
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
        check("done", 32'(done), 32'd1);
        check("req_lo_done", 32'(mem_req), 32'd0);
        check("wb_en", 32'(wb_en), 32'(ok));
        check("fault", 32'(fault), 32'(!ok));
        check("fault_cause", 32'(fault_cause), 32'(cause));
        check("wb_data", wb_data, exp_wb);
        check("wb_rd_done", 32'(wb_rd), 32'(r));
        step();
        mem_ack = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("cause_hold", 32'(fault_cause), 32'(cause));
        check("wb_data_hold", wb_data, exp_wb);
    endtask

    task automatic busy_test();
        logic [31:0] w;
        w = 32'hCAFE_F00D;
        start = 1'b1; funct3 = 3'b010; addr = 32'h300; rd = 5'd5;
        step();
        start = 1'b0;
        check("bz_req1", 32'(mem_req), 32'd1);
        step();
        start = 1'b1; funct3 = 3'b000; addr = 32'h555; rd = 5'd9;
        check("bz_req2", 32'(mem_req), 32'd1);
        step();
        start = 1'b0;
        mem_ack = 1'b1; mem_rdata = w;
        check("bz_addr_kept", mem_addr, 32'h300);
        check("bz_rd_kept", 32'(wb_rd), 32'd5);
        step();
        mem_ack = 1'b0;
        exp_wb = w;
        check("bz_done", 32'(done), 32'd1);
        check("bz_wb_en", 32'(wb_en), 32'd1);
        check("bz_data", wb_data, exp_wb);
        check("bz_rd", 32'(wb_rd), 32'd5);
        step();
        check("bz_idle", 32'(busy), 32'd0);
    endtask

    task automatic reset_test();
        start = 1'b1; funct3 = 3'b010; addr = 32'h400; rd = 5'd7;
        step();
        start = 1'b0;
        step();
        check("rst_pre_req", 32'(mem_req), 32'd1);
        RST_N = 1'b0;
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_cause", 32'(fault_cause), 32'd0);
        mem_ack = 1'b1;
        step();
        check("rst_hold_done", 32'(done), 32'd0);
        RST_N = 1'b1;
        mem_ack = 1'b0;
        exp_wb = 32'd0;
        step();
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; exp_wb = 32'd0;
        RST_N = 1'b0; start = 1'b0; funct3 = 3'd0; addr = 32'd0; rd = 5'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_req", 32'(mem_req), 32'd0);
        check("reset_wb_data", wb_data, 32'd0);
        check("reset_cause", 32'(fault_cause), 32'd0);
        step(); step();
        RST_N = 1'b1;
        step();

        do_load(3'b010, 32'h100, 5'd16, 1, 32'hDEAD_BEEF);
        do_load(3'b000, 32'h103, 5'd1, 1, 32'h80FF_1234);
        do_load(3'b100, 32'h103, 5'd2, 2, 32'h80FF_1234);
        do_load(3'b000, 32'h101, 5'd3, 1, 32'h80FF_1234);
        do_load(3'b001, 32'h202, 5'd4, 1, 32'h8001_7FFF);
        do_load(3'b101, 32'h202, 5'd5, 3, 32'h8001_7FFF);
        do_load(3'b001, 32'h200, 5'd6, 1, 32'h8001_7FFF);
        do_load(3'b010, 32'h102, 5'd7, 1, 32'h1111_1111);
        do_load(3'b011, 32'h101, 5'd8, 1, 32'h2222_2222);
        do_load(3'b010, 32'h500, 5'd9, 0, 32'h3333_3333);
        do_load(3'b010, 32'h504, 5'd10, TO, 32'h4444_4444);
        busy_test();
        reset_test();
        do_load(3'b010, 32'h600, 5'd11, 2, 32'h5555_AAAA);

        for (int i = 0; i < 80; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (f3 == 3'b010) ? 2'b00 : {a[1], 1'b0};
            do_load(f3, a, 5'($urandom), $urandom_range(0, TO + 2), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_load_unit.md
# mem_load_unit

Load execution unit of the RV32I datapath, sitting directly downstream of the I-type load decoder. When a load is issued, it latches the effective address (rs1 + imm), funct3 and rd. It performs a word-aligned read on the data-memory port through a req/ack handshake, then extracts and sign- or zero-extends the addressed byte, halfword or word. Finally it presents the result to register-file writeback with a one-cycle done pulse. Misaligned accesses, illegal funct3 values and memory timeouts are reported as faults instead of writing back.

## Interface
- TIMEOUT, default 15: maximum number of REQ cycles without `mem_ack` before a timeout fault; 0 disables the timeout.

- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- start  in  1  issue pulse; sampled only in IDLE.
- funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- addr  in  32  effective byte address.
- rd  in  5  destination register.
- mem_addr  out  32  word-aligned read address, `{addr[31:2],2'b00}`; registered.
- mem_req  out  1  read request.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  32  read data, little-endian.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse (success or fault).
- wb_en  out  1  register write enable; asserted only together with `done` on success.
- wb_rd  out  5  destination register, registered.
- wb_data  out  32  extended load result, registered.
- fault  out  1  asserted together with `done` on failure.
- fault_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout, 00 none.

## Operation
- FSM states: IDLE, REQ, DONE, FAULT.
- **IDLE**, on `start`:
  - Latch `addr`, `funct3` and `rd`; drive `mem_addr` and `wb_rd` from them.
  - Illegal funct3 (011/110/111): go to FAULT with cause 10.
  - Misaligned access (LH/LHU with `addr[0]=1`, or LW with `addr[1:0]≠0`): go to FAULT with cause 01.
  - Illegal funct3 takes priority over misalignment.
  - Otherwise go to REQ and clear the timeout counter.
  - `start` while `busy` is ignored; the latched values do not change.
- **REQ**:
  - `mem_req=1`.
  - If `mem_ack=1`: capture the formatted `mem_rdata` into `wb_data`, go to DONE.
  - Else increment the counter. When it reaches TIMEOUT (TIMEOUT≠0), go to FAULT with cause 11.
  - Ack in the same cycle as the count expiring takes priority: the load completes normally.
- **DONE**: `done=1`, `wb_en=1`, then go to IDLE.
- **FAULT**: `done=1`, `fault=1`, `fault_cause` valid, `wb_en=0`, `wb_data` unchanged, then go to IDLE.
- Formatting uses `off=addr[1:0]`:
  - LB/LBU use byte `mem_rdata[8*off+7:8*off]`.
  - LH/LHU use halfword `mem_rdata[16*off[1]+15:16*off[1]]`.
  - LW uses the whole word.
  - Signed types replicate the MSB into the upper bits; unsigned types zero-fill.
- `mem_ack` outside REQ is ignored. `mem_rdata` is sampled only on the ack cycle.
- `fault_cause` holds its value until the next `start` is accepted, then clears to 00.

## Timing
- Reset (asynchronous, immediate):
  - State returns to IDLE.
  - `mem_req`, `busy`, `done`, `wb_en` and `fault` go to 0.
  - `mem_addr`, `wb_data`, `wb_rd` and `fault_cause` go to 0.
- Reset mid-operation aborts the load: `mem_req` drops without waiting for a clock edge, and no `done` is produced. The first `start` after reset release is accepted normally.
- Successful load, with `start` in cycle 0:
  - `mem_req` is high from cycle 1.
  - If ack arrives in cycle k (k≥1), `done`, `wb_en` and the new `wb_data` appear in cycle k+1, and `busy` clears in cycle k+2.
  - Minimum latency from start to done is 2 cycles.
- Decode fault: `done` and `fault` appear in cycle 1; `mem_req` is never asserted.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles, and `done`/`fault` appear in the following cycle.
- Back-to-back operation: the next `start` can be accepted in the first cycle after `done`.

## Test plan
- **LW basic:** LW, `addr=0x100`, `rd=16`, ack in cycle 1, `rdata=0xDEADBEEF` -> `mem_addr=0x100`, `done=wb_en=1` in cycle 2, `wb_data=0xDEADBEEF`, `wb_rd=16`.
- **Byte extension:** LB `addr=0x103`, `rdata=0x80FF1234` -> `wb_data=0xFFFFFF80`; LBU at the same address -> `0x00000080`; LB `addr=0x101` -> `0x00000012`.
- **Halfword extension:** LH `addr=0x202`, `rdata=0x80017FFF` -> `wb_data=0xFFFF8001`; LHU -> `0x00008001`; LH `addr=0x200` -> `0x00007FFF`.
- **Decode faults:** LW `addr=0x102` -> no `mem_req`, `done=fault=1` in cycle 1, cause 01, `wb_en=0`, `wb_data` unchanged. funct3=011 with `addr=0x101` -> cause 10.
- **Timeout (TIMEOUT=4):**
  - Ack never arrives -> `mem_req` high in cycles 1-4, fault with cause 11 in cycle 5.
  - Ack in cycle 4 -> normal done in cycle 5, no fault.
- **Reset and busy:** ack delayed 3 cycles with a second `start` in cycle 2 -> the second start is ignored and the first result is correct. Pulling `RST_N` low during REQ -> `mem_req=0` immediately, no `done`, all outputs 0.
